// File: rtl/text_console_pkg.sv
// Shared constants, FSM state encoding and cell-address helper for the text console writer.
package text_console_pkg;

  localparam int COLS          = 80;
  localparam int ROWS          = 30;
  localparam int WORDS_PER_ROW = 20;
  localparam int VRAM_WORDS    = 600;

  localparam logic [6:0] LAST_COL        = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW        = 5'(ROWS - 1);
  localparam logic [9:0] LAST_WORD       = 10'(VRAM_WORDS - 1);
  localparam logic [9:0] LAST_SCROLL_DST = 10'(VRAM_WORDS - WORDS_PER_ROW - 1);
  localparam logic [9:0] ROW_SPAN        = 10'(WORDS_PER_ROW);

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUT       = 3'd1,
    ADVANCE   = 3'd2,
    CLEAR     = 3'd3,
    SCR_RD    = 3'd4,
    SCR_WAIT  = 3'd5,
    SCR_WR    = 3'd6,
    SCR_BLANK = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD = 3'd0,
    CUR_HOME = 3'd1,
    CUR_CR   = 3'd2,
    CUR_LF   = 3'd3,
    CUR_BS   = 3'd4,
    CUR_ADV  = 3'd5
  } cur_op_t;

  // row*20 + col/4, built from shifts so it stays within 10 bits
  function automatic logic [9:0] cell_word_addr(input logic [4:0] row, input logic [6:0] col);
    return ({5'd0, row} << 4) + ({5'd0, row} << 2) + {5'd0, col[6:2]};
  endfunction

endpackage

// File: rtl/text_console_writer_cursor.sv
// Cursor column/row registers with wrap handling; exposes the VRAM word address and byte lane of the cursor cell.
// Row overflow stays on the last row when TEXT_CONSOLE_SCROLL_EN is defined, otherwise wraps to row 0.
module console_cursor
  import text_console_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  cur_op_t    i_op,
  output logic [6:0] o_col,
  output logic [4:0] o_row,
  output logic [9:0] o_word_addr,
  output logic [1:0] o_lane,
  output logic       o_col_last,
  output logic       o_row_last
);

  logic [6:0] r_col;
  logic [4:0] r_row;
  logic [4:0] w_row_next;

`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam logic [4:0] ROW_WRAP = LAST_ROW;
`else
  localparam logic [4:0] ROW_WRAP = 5'd0;
`endif

  always_comb begin
    if (r_row == LAST_ROW) begin
      w_row_next = ROW_WRAP;
    end else begin
      w_row_next = r_row + 5'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col <= 7'd0;
      r_row <= 5'd0;
    end else begin
      case (i_op)
        CUR_HOME: begin
          r_col <= 7'd0;
          r_row <= 5'd0;
        end
        CUR_CR: r_col <= 7'd0;
        CUR_LF: begin
          r_col <= 7'd0;
          r_row <= w_row_next;
        end
        CUR_BS: begin
          if (r_col != 7'd0) begin
            r_col <= r_col - 7'd1;
          end else begin
            r_col <= r_col;
          end
        end
        CUR_ADV: begin
          if (r_col == LAST_COL) begin
            r_col <= 7'd0;
            r_row <= w_row_next;
          end else begin
            r_col <= r_col + 7'd1;
          end
        end
        default: begin
          r_col <= r_col;
          r_row <= r_row;
        end
      endcase
    end
  end

  assign o_col       = r_col;
  assign o_row       = r_row;
  assign o_word_addr = cell_word_addr(r_row, r_col);
  assign o_lane      = r_col[1:0];
  assign o_col_last  = (r_col == LAST_COL);
  assign o_row_last  = (r_row == LAST_ROW);

endmodule

// File: rtl/text_console_writer.sv
// Character-stream to 80x30 text VRAM writer (Avalon-MM master) with control codes CR/LF/BS/FF.
// Define TEXT_CONSOLE_SCROLL_EN to build the scroll-up sequence; otherwise row overflow wraps to row 0.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter logic [7:0] BLANK_CODE = 8'h20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CH_VALID,
  input  logic [7:0]  CH_DATA,
  output logic        CH_READY,
  output logic [9:0]  AVM_ADDR,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST,
  output logic [6:0]  CUR_COL,
  output logic [4:0]  CUR_ROW,
  output logic        BUSY
);

  state_t     r_state, w_next;
  logic [7:0] r_byte;
  logic [9:0] r_word;
  cur_op_t    w_cur_op;
  logic [9:0] w_cell_addr;
  logic [1:0] w_lane;
  logic       w_col_last, w_row_last, w_ctrl, w_row_adv;

  console_cursor u_cursor (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_op        (w_cur_op),
    .o_col       (CUR_COL),
    .o_row       (CUR_ROW),
    .o_word_addr (w_cell_addr),
    .o_lane      (w_lane),
    .o_col_last  (w_col_last),
    .o_row_last  (w_row_last)
  );

  assign w_ctrl    = (r_byte == CC_CR) || (r_byte == CC_LF) || (r_byte == CC_BS);
  assign w_row_adv = (r_byte == CC_LF) || (!w_ctrl && w_col_last);

`ifdef TEXT_CONSOLE_SCROLL_EN
  logic [31:0] r_rdata;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^AVM_READDATA;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: latched byte, word counter (clear / scroll), captured read word
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_byte <= 8'd0;
      r_word <= 10'd0;
`ifdef TEXT_CONSOLE_SCROLL_EN
      r_rdata <= 32'd0;
`endif
    end else begin
      if (r_state == IDLE && CH_VALID) begin
        r_byte <= CH_DATA;
      end
      case (r_state)
        IDLE: r_word <= 10'd0;
        CLEAR: if (!AVM_WAITREQUEST) r_word <= r_word + 10'd1;
`ifdef TEXT_CONSOLE_SCROLL_EN
        SCR_WAIT: r_rdata <= AVM_READDATA;
        SCR_WR, SCR_BLANK: if (!AVM_WAITREQUEST) r_word <= r_word + 10'd1;
`endif
        default: r_word <= r_word;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    w_cur_op = CUR_HOLD;
    case (r_state)
      IDLE: begin
        if (CH_VALID) begin
          case (CH_DATA)
            CC_CR, CC_LF, CC_BS: w_next = ADVANCE;
            CC_FF:               w_next = CLEAR;
            default:             w_next = PUT;
          endcase
        end else begin
          w_next = IDLE;
        end
      end
      PUT: w_next = AVM_WAITREQUEST ? PUT : ADVANCE;
      ADVANCE: begin
        case (r_byte)
          CC_CR:   w_cur_op = CUR_CR;
          CC_LF:   w_cur_op = CUR_LF;
          CC_BS:   w_cur_op = CUR_BS;
          default: w_cur_op = CUR_ADV;
        endcase
`ifdef TEXT_CONSOLE_SCROLL_EN
        w_next = (w_row_adv && w_row_last) ? SCR_RD : IDLE;
`else
        w_next = IDLE;
`endif
      end
      CLEAR: begin
        if (!AVM_WAITREQUEST && r_word == LAST_WORD) begin
          w_next   = IDLE;
          w_cur_op = CUR_HOME;
        end else begin
          w_next = CLEAR;
        end
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD:   w_next = AVM_WAITREQUEST ? SCR_RD : SCR_WAIT;
      SCR_WAIT: w_next = SCR_WR;
      SCR_WR: begin
        if (AVM_WAITREQUEST) begin
          w_next = SCR_WR;
        end else begin
          w_next = (r_word == LAST_SCROLL_DST) ? SCR_BLANK : SCR_RD;
        end
      end
      SCR_BLANK: w_next = (!AVM_WAITREQUEST && r_word == LAST_WORD) ? IDLE : SCR_BLANK;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs decode from registered state only, so they hold steady under waitrequest
  always_comb begin
    AVM_ADDR      = 10'd0;
    AVM_READ      = 1'b0;
    AVM_WRITE     = 1'b0;
    AVM_BYTE_EN   = 4'd0;
    AVM_WRITEDATA = 32'd0;
    case (r_state)
      PUT: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = w_cell_addr;
        AVM_BYTE_EN   = 4'b0001 << w_lane;
        AVM_WRITEDATA = {4{r_byte}};
      end
      CLEAR: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = r_word;
        AVM_BYTE_EN   = 4'hF;
        AVM_WRITEDATA = {4{BLANK_CODE}};
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD: begin
        AVM_READ = 1'b1;
        AVM_ADDR = r_word + ROW_SPAN;
      end
      SCR_WR: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = r_word;
        AVM_BYTE_EN   = 4'hF;
        AVM_WRITEDATA = r_rdata;
      end
      SCR_BLANK: begin
        AVM_WRITE     = 1'b1;
        AVM_ADDR      = r_word;
        AVM_BYTE_EN   = 4'hF;
        AVM_WRITEDATA = {4{BLANK_CODE}};
      end
`endif
      default: begin
        AVM_WRITE = 1'b0;
      end
    endcase
  end

  assign CH_READY = (r_state == IDLE);
  assign BUSY     = (r_state != IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench: VRAM slave model plus a character-grid reference model of the console.
module tb_text_console_writer;
  import text_console_pkg::*;

`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, CH_VALID, CH_READY, AVM_READ, AVM_WRITE, AVM_WAITREQUEST, BUSY;
  logic [7:0]  CH_DATA;
  logic [9:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA, AVM_READDATA;
  logic [6:0]  CUR_COL;
  logic [4:0]  CUR_ROW;

  text_console_writer dut (
    .CLK(CLK), .RESET(RESET), .CH_VALID(CH_VALID), .CH_DATA(CH_DATA), .CH_READY(CH_READY),
    .AVM_ADDR(AVM_ADDR), .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE), .AVM_BYTE_EN(AVM_BYTE_EN),
    .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_READDATA(AVM_READDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST),
    .CUR_COL(CUR_COL), .CUR_ROW(CUR_ROW), .BUSY(BUSY)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic       rd;
    logic [9:0] addr;
    logic [3:0] be;
    logic [31:0] data;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  logic [31:0] vram [600];
  logic [7:0]  scr  [30][80];
  int          n_cmp = 0, n_bad = 0;
  int          exp_col = 0, exp_row = 0;
  int          stall_left = 0, wr_high = 0;
  bit          rand_wait = 1'b0;
  int          last_rdy = 0;
  logic        last_first_wr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Slave: samples mid-cycle, applies accepted transfers after the edge, drives waitrequest/readdata
  initial begin : slave
    logic pend_w, pend_r, prev_stall, seen_wr;
    logic [48:0] prev_sig;
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    AVM_WAITREQUEST = 1'b0;
    AVM_READDATA = 32'd0;
    prev_stall = 1'b0;
    prev_sig = 49'd0;
    forever begin
      @(negedge CLK);
      pend_w = 1'b0; pend_r = 1'b0; seen_wr = 1'b0;
      a = AVM_ADDR; be = AVM_BYTE_EN; d = AVM_WRITEDATA;
      if (!RESET) begin
        if (AVM_READ && AVM_WRITE) chk("rd_wr_together", 64'(AVM_READ & AVM_WRITE), 64'd0);
        if (prev_stall)
          chk("stall_stable", 64'({AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}), 64'(prev_sig));
        seen_wr = AVM_WRITE;
        if (AVM_WRITE) wr_high++;
        if (AVM_WRITE && !AVM_WAITREQUEST) begin
          obs_q.push_back('{1'b0, a, be, d});
          pend_w = 1'b1;
        end
        if (AVM_READ && !AVM_WAITREQUEST) begin
          obs_q.push_back('{1'b1, a, 4'h0, 32'h0});
          pend_r = 1'b1;
        end
        prev_stall = (AVM_WRITE || AVM_READ) && AVM_WAITREQUEST;
        prev_sig = {AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA};
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge CLK);
      #1;
      if (RESET) begin
        if (pend_w || pend_r) void'(obs_q.pop_back());
        prev_stall = 1'b0;
      end else begin
        if (pend_w)
          for (int k = 0; k < 4; k++)
            if (be[k]) vram[a][8*k +: 8] = d[8*k +: 8];
        if (pend_r) AVM_READDATA = vram[a];
      end
      if (stall_left > 0 && seen_wr) stall_left--;
      AVM_WAITREQUEST = (stall_left > 0) ? 1'b1 : (rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0);
    end
  end

  function automatic logic [31:0] scr_word(input int w);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = scr[w / 20][(w % 20) * 4 + k];
    return v;
  endfunction

  task automatic model_newline();
    if (exp_row < 29) begin
      exp_row++;
    end else if (SCROLL) begin
      for (int d = 0; d < 580; d++) begin
        exp_q.push_back('{1'b1, 10'(d + 20), 4'h0, 32'h0});
        exp_q.push_back('{1'b0, 10'(d), 4'hF, scr_word(d + 20)});
      end
      for (int d = 580; d < 600; d++) exp_q.push_back('{1'b0, 10'(d), 4'hF, 32'h20202020});
      for (int r = 0; r < 29; r++)
        for (int c = 0; c < 80; c++) scr[r][c] = scr[r + 1][c];
      for (int c = 0; c < 80; c++) scr[29][c] = 8'h20;
    end else begin
      exp_row = 0;
    end
  endtask

  task automatic model_char(input logic [7:0] b);
    exp_q.delete();
    if (b == 8'h0D) begin
      exp_col = 0;
    end else if (b == 8'h0A) begin
      exp_col = 0;
      model_newline();
    end else if (b == 8'h08) begin
      if (exp_col > 0) exp_col--;
    end else if (b == 8'h0C) begin
      for (int w = 0; w < 600; w++) exp_q.push_back('{1'b0, 10'(w), 4'hF, 32'h20202020});
      for (int r = 0; r < 30; r++)
        for (int c = 0; c < 80; c++) scr[r][c] = 8'h20;
      exp_col = 0;
      exp_row = 0;
    end else begin
      exp_q.push_back('{1'b0, 10'(exp_row * 20 + exp_col / 4), 4'(1 << (exp_col % 4)), {4{b}}});
      scr[exp_row][exp_col] = b;
      exp_col++;
      if (exp_col == 80) begin
        exp_col = 0;
        model_newline();
      end
    end
  endtask

  task automatic chk_events(input string tag);
    int nb = 0;
    int first = -1;
    string t;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin
        nb++;
        if (first < 0) first = i;
      end
    t = {tag, "_events"};
    if (first >= 0)
      t = $sformatf("%s_events(first bad #%0d obs %h exp %h)", tag, first, obs_q[first], exp_q[first]);
    chk(t, 64'(nb), 64'd0);
  endtask

  task automatic chk_vram(input string tag);
    int nb = 0;
    for (int w = 0; w < 600; w++) if (vram[w] !== scr_word(w)) nb++;
    chk(tag, 64'(nb), 64'd0);
  endtask

  task automatic start_char(input logic [7:0] b);
    int k = 0;
    @(negedge CLK);
    while (!CH_READY && k < 20000) begin
      k++;
      @(negedge CLK);
    end
    CH_VALID = 1'b1;
    CH_DATA  = b;
    @(posedge CLK);
    #1;
    CH_VALID = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] b, input string tag);
    obs_q.delete();
    wr_high = 0;
    start_char(b);
    last_rdy = 0;
    @(negedge CLK);
    last_first_wr = AVM_WRITE;
    while (!CH_READY && last_rdy < 10000) begin
      last_rdy++;
      @(negedge CLK);
    end
    if (!CH_READY) chk({tag, "_timeout"}, 64'(CH_READY), 64'd1);
    model_char(b);
    chk({tag, "_cursor"}, 64'({CUR_ROW, CUR_COL}), 64'({5'(exp_row), 7'(exp_col)}));
    chk_events(tag);
  endtask

  function automatic logic [7:0] rand_print();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D);
    return b;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(CH_READY), 64'd1);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
    chk({tag, "_strobes"}, 64'({AVM_READ, AVM_WRITE}), 64'd0);
    chk({tag, "_bus"}, 64'({AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA}), 64'd0);
    chk({tag, "_cursor"}, 64'({CUR_ROW, CUR_COL}), 64'd0);
  endtask

  initial begin : main
    int k;
    RESET = 1'b1;
    CH_VALID = 1'b0;
    CH_DATA = 8'h00;
    for (int w = 0; w < 600; w++) vram[w] = $urandom;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) scr[r][c] = vram[r * 20 + c / 4][8 * (c % 4) +: 8];
    #1;
    chk_reset_outputs("in_reset");
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk_reset_outputs("after_reset");

    send_char(8'h41, "first_A");
    chk("first_A_strobe_latency", 64'(last_first_wr), 64'd1);
    chk("first_A_ready_latency", 64'(last_rdy), 64'd2);
    for (int i = 0; i < 4; i++) send_char(rand_print(), $sformatf("print%0d", i));
    send_char(CC_LF, "lf");
    send_char(8'hC1, "inverse_C1");
    chk("inverse_C1_ready_latency", 64'(last_rdy), 64'd2);

    @(negedge CLK);
    stall_left = 3;
    send_char(rand_print(), "stall_put");
    chk("stall_write_cycles", 64'(wr_high), 64'd4);
    chk("stall_ready_low", 64'(last_rdy), 64'd5);

    send_char(CC_CR, "cr");
    send_char(CC_FF, "ff");
    chk_vram("vram_after_ff");
    send_char(CC_BS, "bs_col0");
    send_char(rand_print(), "print_bs");
    send_char(CC_BS, "bs_col1");

    rand_wait = 1'b1;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7)       send_char(rand_print(), $sformatf("rnd%0d", i));
      else if (k == 7) send_char(CC_CR, $sformatf("rnd%0d", i));
      else if (k == 8) send_char(CC_LF, $sformatf("rnd%0d", i));
      else             send_char(CC_BS, $sformatf("rnd%0d", i));
    end
    chk_vram("vram_after_random");

    send_char(CC_FF, "ff_fill");
    for (int i = 0; i < 29; i++) send_char(CC_LF, $sformatf("fill_lf%0d", i));
    for (int i = 0; i < 79; i++) send_char(rand_print(), $sformatf("fill_col%0d", i));
    send_char(rand_print(), "overflow");
    chk("overflow_reads", 64'(SCROLL ? 580 : 0), 64'(obs_q.size() - wr_high + (wr_high - 0) - obs_q.size() + (obs_q.size() - (SCROLL ? 601 : 1))));
    chk_vram("vram_after_overflow");

    rand_wait = 1'b0;
    obs_q.delete();
`ifdef TEXT_CONSOLE_SCROLL_EN
    start_char(CC_LF);
    k = 0;
    while (!(AVM_READ && AVM_ADDR == 10'd120) && k < 20000) begin
      k++;
      @(negedge CLK);
    end
    chk("reach_scroll_dst100", 64'({AVM_READ, AVM_ADDR}), 64'({1'b1, 10'd120}));
`else
    start_char(CC_FF);
    k = 0;
    while (!(AVM_WRITE && AVM_ADDR == 10'd100) && k < 20000) begin
      k++;
      @(negedge CLK);
    end
    chk("reach_clear_word100", 64'({AVM_WRITE, AVM_ADDR}), 64'({1'b1, 10'd100}));
`endif
    #2;
    RESET = 1'b1;
    #1;
    chk_reset_outputs("mid_op_reset");
    @(negedge CLK);
    RESET = 1'b0;
    exp_col = 0;
    exp_row = 0;
    @(negedge CLK);
    chk_reset_outputs("post_mid_reset");
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) scr[r][c] = vram[r * 20 + c / 4][8 * (c % 4) +: 8];
    send_char(CC_FF, "ff_recover");
    chk_vram("vram_after_recover");
    send_char(8'h41, "final_A");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
